// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial transmit scheduler.
// Optional parity frame slot is enabled by defining SERIAL_PARITY_EN.
package serial_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_WORD_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
`ifdef SERIAL_PARITY_EN
        PAR,
`endif
        LATCH
    } state_e;

endpackage

// File: rtl/serial_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: first active request at or after the pointer wins.
// Purely combinational; used by serial_tx_scheduler (SERIAL_PARITY_EN has no effect here).
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDX_W-1:0]   grant_idx_c
);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        found       = 1'b0;
        idx         = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(pointer) + i) % NUM_REQ;
            if (enable && !found && req[IDX_W'(idx)]) begin
                found                = 1'b1;
                grant_c[IDX_W'(idx)] = 1'b1;
                grant_idx_c          = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Arbitrates NUM_REQ parallel words onto one LSB-first serial link with an
// active-low end-of-frame latch strobe. Define SERIAL_PARITY_EN for an even-parity slot.
module serial_tx_scheduler
    import serial_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter  int unsigned WORD_W  = DEF_WORD_W,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*WORD_W-1:0] data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      s_out,
    output logic                      latch,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_id
);

    localparam int unsigned CNT_W = $clog2(WORD_W);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                s_out_q, s_out_d;
    logic                latch_q, latch_d;
    logic                busy_q, busy_d;
    logic [IDX_W-1:0]    gid_q, gid_d;
`ifdef SERIAL_PARITY_EN
    logic                par_q, par_d;
`endif

    logic [WORD_W-1:0]   words [NUM_REQ];
    logic [WORD_W-1:0]   cap_word;
    logic [NUM_REQ-1:0]  arb_grant_c;
    logic [IDX_W-1:0]    arb_idx_c;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign words[i] = data[i*WORD_W +: WORD_W];
    end

    assign cap_word = words[arb_idx_c];

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req         (req),
        .pointer     (ptr_q),
        .enable      (state_q == IDLE),
        .grant_c     (arb_grant_c),
        .grant_idx_c (arb_idx_c)
    );

    // Outputs are computed for the next cycle so bit 0 lines up with ack.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        ack_d   = '0;
        s_out_d = 1'b0;
        latch_d = 1'b1;
`ifdef SERIAL_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = SHIFT;
                    shreg_d = cap_word >> 1;
                    s_out_d = cap_word[0];
                    cnt_d   = '0;
                    ack_d   = arb_grant_c;
                    gid_d   = arb_idx_c;
                    ptr_d   = (arb_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx_c + IDX_W'(1);
`ifdef SERIAL_PARITY_EN
                    par_d   = ^cap_word;
`endif
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(WORD_W - 1)) begin
`ifdef SERIAL_PARITY_EN
                    state_d = PAR;
                    s_out_d = par_q;
`else
                    state_d = LATCH;
                    latch_d = 1'b0;
`endif
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    s_out_d = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
`ifdef SERIAL_PARITY_EN
            PAR: begin
                state_d = LATCH;
                latch_d = 1'b0;
            end
`endif
            LATCH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gid_q   <= '0;
            ack_q   <= '0;
            s_out_q <= 1'b0;
            latch_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef SERIAL_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            ack_q   <= ack_d;
            s_out_q <= s_out_d;
            latch_q <= latch_d;
            busy_q  <= busy_d;
`ifdef SERIAL_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign ack      = ack_q;
    assign s_out    = s_out_q;
    assign latch    = latch_q;
    assign busy     = busy_q;
    assign grant_id = gid_q;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Directed scoreboard bench for serial_tx_scheduler (default parameters).
module tb_serial_tx_scheduler;

    localparam int NR = 4;
    localparam int WW = 16;
`ifdef SERIAL_PARITY_EN
    localparam int TAIL = 1;
`else
    localparam int TAIL = 0;
`endif
    localparam int FRAME = WW + 2 + TAIL;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req;
    logic [NR*WW-1:0] data;
    logic [NR-1:0]    ack;
    logic             s_out;
    logic             latch;
    logic             busy;
    logic [1:0]       grant_id;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int cyc    = 0;

    typedef struct {
        int           id;
        logic [WW-1:0] word;
    } exp_t;
    exp_t sb[$];

    serial_tx_scheduler #(.NUM_REQ(NR), .WORD_W(WW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .data     (data),
        .ack      (ack),
        .s_out    (s_out),
        .latch    (latch),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int id, input logic [WW-1:0] w);
        data[id*WW +: WW] = w;
    endtask

    task automatic push(input int id, input logic [WW-1:0] w);
        exp_t e;
        e.id   = id;
        e.word = w;
        sb.push_back(e);
    endtask

    task automatic wait_ack(output bit got);
        int n;
        n = 0;
        tick();
        while (ack == '0 && n < 40) begin
            tick();
            n++;
        end
        got = (ack != '0);
        check("ack_seen", 32'(got), 32'd1);
    endtask

    // Pops the expected frame, follows it bit by bit, and applies req edits mid-frame.
    task automatic check_frame(input bit drop_own, input int set_bit, input logic [NR-1:0] set_mask,
                               input int clr_bit, input logic [NR-1:0] clr_mask, output int ack_cyc);
        exp_t e;
        bit   got;
        ack_cyc = 0;
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        wait_ack(got);
        ack_cyc = cyc;
        if (!got) return;
        check("ack_onehot", 32'(ack), 32'd1 << e.id);
        check("grant_id", 32'(grant_id), 32'(e.id));
        check("busy_shift", 32'(busy), 32'd1);
        if (drop_own) req[e.id] = 1'b0;
        for (int k = 0; k < WW; k++) begin
            if (k > 0) tick();
            check($sformatf("bit%0d", k), 32'(s_out), 32'(e.word[k]));
            check($sformatf("latch_hi%0d", k), 32'(latch), 32'd1);
            if (k == 1) check("ack_pulse", 32'(ack), 32'd0);
            if (k == set_bit) req = req | set_mask;
            if (k == clr_bit) req = req & ~clr_mask;
        end
`ifdef SERIAL_PARITY_EN
        tick();
        check("parity", 32'(s_out), 32'(^e.word));
        check("latch_hi_par", 32'(latch), 32'd1);
`endif
        tick();
        check("latch_low", 32'(latch), 32'd0);
        check("s_out_latch", 32'(s_out), 32'd0);
        check("latch_cycle", 32'(cyc - ack_cyc), 32'(WW + TAIL));
        check("grant_hold", 32'(grant_id), 32'(e.id));
        tick();
        check("latch_idle", 32'(latch), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int  a0, a1;
        int  seen_ack, seen_busy;
        bit  got;

        // Reset dominates a pending request.
        reset = 1'b1;
        req   = 4'b0001;
        data  = '0;
        set_word(0, 16'hA5C3);
        tick();
        tick();
        check("rst_s_out", 32'(s_out), 32'd0);
        check("rst_latch", 32'(latch), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);

        // Single frame from requester 0.
        reset = 1'b0;
        push(0, 16'hA5C3);
        check_frame(1'b1, -1, '0, -1, '0, a0);

        // All requesters held high: rotation 0,1,2,3,0 at full frame rate.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_word(0, 16'h1111);
        set_word(1, 16'h2222);
        set_word(2, 16'h4C4C);
        set_word(3, 16'h8001);
        req = 4'b1111;
        push(0, 16'h1111);
        push(1, 16'h2222);
        push(2, 16'h4C4C);
        push(3, 16'h8001);
        push(0, 16'h1111);
        a1 = 0;
        for (int i = 0; i < 5; i++) begin
            check_frame(1'b0, -1, '0, -1, '0, a0);
            if (i > 0) check($sformatf("period%0d", i), 32'(a0 - a1), 32'(FRAME));
            a1 = a0;
        end
        req = '0;

        // Requester 2 arrives during requester 1's frame and follows in the next IDLE.
        set_word(1, 16'h1234);
        set_word(2, 16'hBEEF);
        req = 4'b0010;
        push(1, 16'h1234);
        push(2, 16'hBEEF);
        check_frame(1'b1, 5, 4'b0100, -1, '0, a0);
        check_frame(1'b1, -1, '0, -1, '0, a1);
        check("late_req_gap", 32'(a1 - a0), 32'(FRAME));

        // Requester 3 pulses only while busy: never served.
        set_word(0, 16'h0F0F);
        set_word(3, 16'hFFFF);
        req = 4'b0001;
        push(0, 16'h0F0F);
        check_frame(1'b1, 3, 4'b1000, 10, 4'b1000, a0);
        seen_ack  = 0;
        seen_busy = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (ack != '0) seen_ack = 1;
            if (busy) seen_busy = 1;
        end
        check("withdrawn_ack", 32'(seen_ack), 32'd0);
        check("withdrawn_busy", 32'(seen_busy), 32'd0);

        // Reset mid-frame at bit 7; pointer returns to 0.
        set_word(0, 16'h5A5A);
        set_word(1, 16'hFFFF);
        set_word(2, 16'h0003);
        req = 4'b0010;
        wait_ack(got);
        check("abort_ack", 32'(ack), 32'd2);
        for (int k = 1; k <= 7; k++) tick();
        check("abort_bit7", 32'(s_out), 32'd1);
        reset = 1'b1;
        req   = 4'b0101;
        tick();
        check("abort_s_out", 32'(s_out), 32'd0);
        check("abort_latch", 32'(latch), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack0", 32'(ack), 32'd0);
        reset = 1'b0;
        push(0, 16'h5A5A);
        check_frame(1'b1, -1, '0, -1, '0, a0);
        req = '0;
        tick();

`ifdef SERIAL_PARITY_EN
        // Odd-weight word: parity slot carries 1, latch at frame cycle 19.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_word(0, 16'h0007);
        req = 4'b0001;
        push(0, 16'h0007);
        check_frame(1'b1, -1, '0, -1, '0, a0);
`endif

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_tx_scheduler.md
SERIAL_TX_SCHEDULER -- requirements
Module: serial_tx_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing the serial link (range 2..8).
REQ-002 The block SHALL have parameter WORD_W, default 16, giving the width of each parallel word.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, NUM_REQ bits: per-requester transmit request, level-held until ack.
REQ-006 The block SHALL have port data, input, NUM_REQ*WORD_W bits: flattened words, requester i at bits [i*WORD_W +: WORD_W], stable while req[i]=1.
REQ-007 The block SHALL have port ack, output, NUM_REQ bits: one-cycle pulse to the requester whose word was captured.
REQ-008 The block SHALL have port s_out, output, 1 bit: serial data, LSB first.
REQ-009 The block SHALL have port latch, output, 1 bit: active-low end-of-frame strobe, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 The block SHALL have port grant_id, output, clog2(NUM_REQ) bits: index of the requester currently owning the link, held from capture to end of frame.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT, PAR (present only with the macro), and LATCH.
REQ-013 In IDLE with req!=0, the next edge SHALL select winner g by round-robin, load data[g] into the shift register, clear the bit counter, set ack[g]=1 for exactly one cycle, set grant_id=g, and enter SHIFT.
REQ-014 Round-robin SHALL give highest priority to index (last_grant+1) mod NUM_REQ; after reset the highest priority SHALL be index 0.
REQ-015 In SHIFT, s_out SHALL equal bit k of the captured word during the k-th SHIFT cycle (k=0..WORD_W-1), so bit 0 appears in the same cycle that ack is high.
REQ-016 After the SHIFT cycle with k=WORD_W-1, the FSM SHALL enter LATCH, or PAR if the macro is defined.
REQ-017 In LATCH, latch SHALL be 0 for exactly one cycle, s_out SHALL be 0, and the next state SHALL be IDLE.
REQ-018 Outside SHIFT and PAR, s_out SHALL be 0; outside LATCH, latch SHALL be 1.
REQ-019 A frame SHALL take 1 IDLE/grant cycle + WORD_W + 1 cycles, i.e. 18 cycles at default without the macro, with a minimum back-to-back period equal to this frame length.
REQ-020 req changes during a frame SHALL NOT affect the current frame; only requests present in IDLE are arbitrated.
REQ-021 A req dropped before its ack SHALL be treated as withdrawn, with no frame sent and no ack issued.
REQ-022 A req still high in the cycle after its ack SHALL be treated as a new request.

Reset
REQ-023 While reset=1, the block SHALL set state=IDLE, s_out=0, latch=1, busy=0, ack=0, grant_id=0, round-robin pointer to index 0, and clear the shift register and counter.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately, with no latch pulse and no further bits.
REQ-025 reset SHALL have priority over every other event in the same cycle.

Configuration
REQ-026 When SERIAL_PARITY_EN is defined, the FSM SHALL insert one PAR cycle after the last data bit in which s_out equals the even-parity bit (XOR of the captured word), making the default frame 19 cycles.
REQ-027 When SERIAL_PARITY_EN is undefined, the FSM SHALL have no PAR state and no parity logic.

Structure
REQ-028 A shared package serial_pkg SHALL hold the FSM state enum and the default constants for WORD_W and NUM_REQ.
REQ-029 The round-robin arbiter SHALL be implemented as sub-module rr_arbiter, with inputs req, pointer, and enable, and outputs a one-hot grant and its index.

Verification
REQ-030 Bench SHALL check: after reset, req[0]=1 with data[0]=16'hA5C3 -> ack[0] pulses once, s_out carries 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 over 16 cycles, then latch=0 for one cycle.
REQ-031 Bench SHALL check: req=4'b1111 held, each requester re-requesting after its ack -> grant order 0,1,2,3,0 with frames 18 cycles apart.
REQ-032 Bench SHALL check: req[2] raised during a frame owned by requester 1 -> no disturbance to the current frame; requester 2 is granted in the next IDLE cycle.
REQ-033 Bench SHALL check: reset pulsed at SHIFT bit 7 -> next cycle s_out=0, latch=1, busy=0, and no ack; the next grant goes to index 0.
REQ-034 Bench SHALL check: req[3] raised and dropped while busy -> no ack[3] and no frame for requester 3.
REQ-035 Bench SHALL check, with SERIAL_PARITY_EN defined: data=16'h0007 -> parity bit 1 is sent after bit 15, and latch falls in cycle 19.
